// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the control_unit sequencer.
// Instruction layout: opcode IR[15:9], literal IR[7:0]; IR[8] unused.
package cu_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_e;

    typedef logic [6:0] opcode_t;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 9;
    localparam int LIT_MSB = 7;

    // Opcode field positions within the 7-bit opcode
    localparam int OP_CLASS  = 6;
    localparam int OP_LOAD_B = 5;
    localparam int OP_LOAD_A = 4;
    localparam int OP_SEL_B  = 3;

    localparam logic [1:0] CLS_JUMP = 2'b10;
    localparam logic [1:0] CLS_HALT = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    localparam logic [2:0] J_JMP = 3'd0;
    localparam logic [2:0] J_JEQ = 3'd1;
    localparam logic [2:0] J_JNE = 3'd2;
    localparam logic [2:0] J_JGT = 3'd3;
    localparam logic [2:0] J_JLT = 3'd4;
    localparam logic [2:0] J_JGE = 3'd5;
    localparam logic [2:0] J_JLE = 3'd6;
    localparam logic [2:0] J_JCR = 3'd7;

    // Status register order is {C,N,Z}
    localparam int F_Z = 0;
    localparam int F_N = 1;
    localparam int F_C = 2;

    function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] f);
        logic z, n, c;
        z = f[F_Z];
        n = f[F_N];
        c = f[F_C];
        case (cond)
            J_JMP:   cond_met = 1'b1;
            J_JEQ:   cond_met = z;
            J_JNE:   cond_met = !z;
            J_JGT:   cond_met = !z && !n;
            J_JLT:   cond_met = n;
            J_JGE:   cond_met = !n;
            J_JLE:   cond_met = z || n;
            default: cond_met = c;
        endcase
    endfunction

endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational opcode decode into datapath controls and jump/halt flags.
module cu_decode
    import cu_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [2:0] flags_i,
    output logic       load_a_o,
    output logic       load_b_o,
    output logic       sel_b_o,
    output logic [2:0] alu_op_o,
    output logic       take_jump_o,
    output logic       is_halt_o
);

    logic is_alu;
    logic is_jump;

    assign is_alu      = !op_i[OP_CLASS];
    assign is_jump     = op_i[6:5] == CLS_JUMP;
    assign is_halt_o   = op_i[6:5] == CLS_HALT;
    assign load_a_o    = is_alu && op_i[OP_LOAD_A];
    assign load_b_o    = is_alu && op_i[OP_LOAD_B];
    assign sel_b_o     = op_i[OP_SEL_B];
    assign alu_op_o    = op_i[2:0];
    assign take_jump_o = is_jump && cond_met(op_i[2:0], flags_i);

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/exec sequencer for the 8-bit accumulator datapath.
// Define CU_WATCHDOG_EN to add a fetch timeout that halts with a sticky fetch_err.
module control_unit
    import cu_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [15:0] instr,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_c,
    output logic        load_a,
    output logic        load_b,
    output logic        sel_b,
    output logic [2:0]  alu_op,
    output logic [7:0]  k,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [7:0]  pc_target,
    output logic [2:0]  flags,
    output logic        halted,
    output logic        fetch_err
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [2:0]  flags_q, flags_d;
    logic        exec;
    logic        dec_load_a, dec_load_b, dec_take, dec_halt;

    cu_decode u_decode (
        .op_i       (ir_q[OP_MSB:OP_LSB]),
        .flags_i    (flags_q),
        .load_a_o   (dec_load_a),
        .load_b_o   (dec_load_b),
        .sel_b_o    (sel_b),
        .alu_op_o   (alu_op),
        .take_jump_o(dec_take),
        .is_halt_o  (dec_halt)
    );

`ifdef CU_WATCHDOG_EN
    localparam int CW = (FETCH_TIMEOUT < 16) ? 4 : $clog2(FETCH_TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          timeout;

    assign timeout   = cnt_q == CW'(FETCH_TIMEOUT - 1);
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        flags_d = flags_q;
`ifdef CU_WATCHDOG_EN
        cnt_d   = (state_q == FETCH) ? cnt_q + 1'b1 : '0;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = instr;
                    state_d = EXEC;
                end
`ifdef CU_WATCHDOG_EN
                else if (timeout) begin
                    state_d = HALT;
                    err_d   = 1'b1;
                end
`endif
            end
            EXEC: begin
                state_d = dec_halt ? HALT : FETCH;
                flags_d = ir_q[OP_MSB] ? flags_q : {alu_c, alu_n, alu_z};
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ir_q    <= '0;
            flags_q <= '0;
`ifdef CU_WATCHDOG_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
`ifdef CU_WATCHDOG_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign exec      = state_q == EXEC;
    assign imem_req  = state_q == FETCH;
    assign halted    = state_q == HALT;
    assign load_a    = exec && dec_load_a;
    assign load_b    = exec && dec_load_b;
    assign pc_load   = exec && dec_take;
    assign pc_inc    = exec && !dec_take && !dec_halt;
    assign k         = ir_q[LIT_MSB:0];
    assign pc_target = ir_q[LIT_MSB:0];
    assign flags     = flags_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed + randomized checks of control_unit against a spec-level model.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset, imem_ack, alu_z, alu_n, alu_c;
    logic [15:0] instr;
    logic        imem_req, load_a, load_b, sel_b, pc_inc, pc_load, halted, fetch_err;
    logic [2:0]  alu_op, flags;
    logic [7:0]  k, pc_target;

    int          tests = 0;
    int          fails = 0;
    logic [2:0]  mflags;

    control_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .load_a(load_a), .load_b(load_b),
        .sel_b(sel_b), .alu_op(alu_op), .k(k), .pc_inc(pc_inc), .pc_load(pc_load),
        .pc_target(pc_target), .flags(flags), .halted(halted), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] strobes();
        return {load_a, load_b, pc_inc, pc_load};
    endfunction

    // Fetch with `dly` stall cycles, then execute; checks both phases against the model.
    task automatic step(input logic [15:0] ins, input int dly, input logic z, input logic n, input logic c);
        int         op, cond;
        bit         is_alu, is_jmp, is_hlt, taken;
        logic [7:0] oldk;
        op     = int'(ins) / 512;
        cond   = op % 8;
        is_alu = op < 64;
        is_jmp = op >= 64 && op < 96;
        is_hlt = op >= 96;
        oldk   = k;
        case (cond)
            0: taken = 1;
            1: taken = mflags[0];
            2: taken = !mflags[0];
            3: taken = !mflags[0] && !mflags[1];
            4: taken = mflags[1];
            5: taken = !mflags[1];
            6: taken = mflags[0] || mflags[1];
            default: taken = mflags[2];
        endcase
        taken = taken && is_jmp;
        for (int i = 0; i <= dly; i++) begin
            chk("fetch_req", 32'(imem_req), 32'd1);
            chk("fetch_strobes", 32'(strobes()), 32'd0);
            chk("fetch_ir_hold", 32'(k), 32'(oldk));
            imem_ack = (i == dly);
            instr    = (i == dly) ? ins : 16'($urandom);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        instr    = 16'($urandom);
        alu_z    = z;
        alu_n    = n;
        alu_c    = c;
        chk("exec_req", 32'(imem_req), 32'd0);
        chk("exec_k", 32'(k), 32'(ins[7:0]));
        chk("exec_target", 32'(pc_target), 32'(ins[7:0]));
        chk("exec_load_a", 32'(load_a), 32'(is_alu && ((op / 16) % 2 == 1)));
        chk("exec_load_b", 32'(load_b), 32'(is_alu && ((op / 32) % 2 == 1)));
        chk("exec_pc_inc", 32'(pc_inc), 32'(is_alu || (is_jmp && !taken)));
        chk("exec_pc_load", 32'(pc_load), 32'(taken));
        if (is_alu) begin
            chk("exec_sel_b", 32'(sel_b), 32'((op / 8) % 2));
            chk("exec_alu_op", 32'(alu_op), 32'(cond));
        end
        @(negedge clk);
        if (is_alu) mflags = {c, n, z};
        chk("post_flags", 32'(flags), 32'(mflags));
        chk("post_halted", 32'(halted), 32'(is_hlt));
        chk("post_req", 32'(imem_req), 32'(!is_hlt));
        chk("post_strobes", 32'(strobes()), 32'd0);
    endtask

    initial begin
        int op;
        reset    = 1'b1;
        imem_ack = 1'b1;
        instr    = 16'hFFFF;
        alu_z    = 1'b1;
        alu_n    = 1'b1;
        alu_c    = 1'b1;
        mflags   = 3'b000;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", {1'b0, imem_req, load_a, load_b, sel_b, alu_op, k, pc_inc, pc_load,
                                  pc_target, flags, halted, fetch_err}, 32'd0);
        end
        imem_ack = 1'b0;
        reset    = 1'b0;
        #1 chk("idle_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("req_after_idle", 32'(imem_req), 32'd1);
        // ALU load literal 5 into A; compare setting Z; JEQ taken; JNE not taken
        step({7'b0011000, 1'b0, 8'h05}, 0, 1'b0, 1'b1, 1'b1);
        step({7'b0000001, 1'b0, 8'h00}, 0, 1'b1, 1'b0, 1'b0);
        chk("cmp_flags", 32'(flags), 32'b001);
        step({7'b1000001, 1'b0, 8'h20}, 0, 1'b0, 1'b0, 1'b0);
        step({7'b1000010, 1'b0, 8'h40}, 0, 1'b1, 1'b1, 1'b1);
        chk("jne_flags_kept", 32'(flags), 32'b001);
        step({7'b0101100, 1'b0, 8'hA5}, 4, 1'b0, 1'b1, 1'b0);
        step({7'b1000000, 1'b0, 8'hFF}, 1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 2) < 2) ? int'($urandom_range(0, 63)) : 64 + int'($urandom_range(0, 31));
            step({7'(op), 1'($urandom), 8'($urandom)}, int'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom));
        end
        reset = 1'b1;
        #1 chk("async_reset_req", 32'(imem_req), 32'd0);
        chk("async_reset_flags", 32'(flags), 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        mflags = 3'b000;
        @(negedge clk);
        step({7'b1100000, 1'b0, 8'h00}, 0, 1'b1, 1'b1, 1'b1);
        repeat (20) begin
            @(negedge clk);
            chk("halt_state", {29'd0, halted, imem_req, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
            chk("halt_strobes", 32'(strobes()), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        mflags = 3'b000;
        @(negedge clk);
        chk("resume_req", 32'(imem_req), 32'd1);
        step({7'b0110011, 1'b0, 8'h3C}, 0, 1'b0, 1'b0, 1'b1);
`ifdef CU_WATCHDOG_EN
        for (int i = 0; i < 15; i++) begin
            chk("wd_wait_req", 32'(imem_req), 32'd1);
            chk("wd_wait_err", 32'(fetch_err), 32'd0);
            @(negedge clk);
        end
        chk("wd_err", 32'(fetch_err), 32'd1);
        chk("wd_halted", 32'(halted), 32'd1);
        chk("wd_req", 32'(imem_req), 32'd0);
`else
        repeat (20) begin
            chk("nowd_req", 32'(imem_req), 32'd1);
            chk("nowd_err", {30'd0, fetch_err, halted}, 32'd0);
            @(negedge clk);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
